// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the exhaustive vector sweeper.
//   state_t      : sequencer states (IDLE, DRIVE, WAIT_STEP)
//   MODE_*       : sweep mode encodings latched on start
//   rotl()       : rotate-left-by-one within a runtime width (width 1..64)
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE     = 2'd1,
        WAIT_STEP = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_CONT    = 2'd1;
    localparam logic [1:0] MODE_STEP    = 2'd2;

    // v is expected to hold no bits above width-1.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ((v << 1) | (v >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/sweep_signature_acc.sv
// Rotate-XOR signature and ones counter for the vector sweeper.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_clear           : zero the running accumulators (wins over i_update)
//   i_update          : fold i_resp into the running accumulators
//   i_latch           : copy the post-update values to the outputs
//   i_resp            : response word being sampled
//   o_signature       : latched signature of the last completed pass
//   o_ones_count      : latched count of samples with resp[0]=1
module sweep_signature_acc
    import sweeper_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned M_OUT = 1,
    parameter int unsigned SIG_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_update,
    input  logic             i_latch,
    input  logic [M_OUT-1:0] i_resp,
    output logic [SIG_W-1:0] o_signature,
    output logic [N_IN:0]    o_ones_count
);

    logic [SIG_W-1:0] r_acc_sig;
    logic [N_IN:0]    r_acc_ones;
    logic [SIG_W-1:0] r_signature;
    logic [N_IN:0]    r_ones_count;
    logic [SIG_W-1:0] w_sig_new;
    logic [N_IN:0]    w_ones_new;

    always_comb begin
        w_sig_new  = SIG_W'(rotl(64'(r_acc_sig), SIG_W)) ^ SIG_W'(i_resp);
        w_ones_new = r_acc_ones + (N_IN+1)'(i_resp[0]);
    end

    // Latching takes the value including the current sample, so a pass
    // that ends and immediately restarts (clear) still reports correctly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc_sig    <= '0;
            r_acc_ones   <= '0;
            r_signature  <= '0;
            r_ones_count <= '0;
        end else begin
            if (i_clear) begin
                r_acc_sig  <= '0;
                r_acc_ones <= '0;
            end else if (i_update) begin
                r_acc_sig  <= w_sig_new;
                r_acc_ones <= w_ones_new;
            end
            if (i_latch) begin
                r_signature  <= w_sig_new;
                r_ones_count <= w_ones_new;
            end
        end
    end

    assign o_signature  = r_signature;
    assign o_ones_count = r_ones_count;

endmodule

// File: rtl/exhaustive_vector_sweeper.sv
// Exhaustive stimulus sequencer: drives every N_IN-bit vector in turn, holds
// each for HOLD_CYCLES clocks, and folds the response sampled on the last
// hold cycle into a signature and ones count.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_start        : begin a sweep (only honoured in IDLE)
//   i_mode         : 0 one-shot, 1 continuous, 2 single-step, 3 as 0
//   i_step         : advance to next vector while waiting in single-step
//   i_abort        : return to IDLE without reporting results
//   i_resp         : response from the swept block
//   o_stim         : stimulus vector
//   o_stim_valid   : stimulus being driven
//   o_resp_valid   : sample-cycle strobe
//   o_sample_idx   : index being sampled (equals o_stim)
//   o_busy         : not IDLE
//   o_done         : one-cycle pulse after each completed pass
//   o_ones_count   : latched ones count of the last completed pass
//   o_signature    : latched signature of the last completed pass
module exhaustive_vector_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned N_IN        = 3,
    parameter int unsigned M_OUT       = 1,
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned SIG_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [M_OUT-1:0] i_resp,
    output logic [N_IN-1:0]  o_stim,
    output logic             o_stim_valid,
    output logic             o_resp_valid,
    output logic [N_IN-1:0]  o_sample_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic [N_IN:0]    o_ones_count,
    output logic [SIG_W-1:0] o_signature
);

    localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN:0] IDX_LAST  = (N_IN+1)'((1 << N_IN) - 1);

    state_t          r_state, w_state_next;
    logic [N_IN:0]   r_idx, w_idx_next;
    logic [HW-1:0]   r_hold, w_hold_next;
    logic [1:0]      r_mode, w_mode_next;
    logic            r_done, w_done_next;
    logic            w_sample, w_last;
    logic            w_clear, w_update, w_latch;

    assign w_sample = (r_state == DRIVE) && (r_hold == HOLD_LAST);
    assign w_last   = (r_idx == IDX_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_mode  <= MODE_ONESHOT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_hold  <= w_hold_next;
            r_mode  <= w_mode_next;
            r_done  <= w_done_next;
        end
    end

    // Every path back to IDLE zeroes the index, so o_stim is 0 there.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_hold_next  = r_hold;
        w_mode_next  = r_mode;
        w_done_next  = 1'b0;
        w_clear      = 1'b0;
        w_update     = 1'b0;
        w_latch      = 1'b0;
        if (i_abort) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
            w_hold_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_mode_next  = (i_mode == 2'd3) ? MODE_ONESHOT : i_mode;
                        w_clear      = 1'b1;
                        w_idx_next   = '0;
                        w_hold_next  = '0;
                        w_state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    if (w_sample) begin
                        w_update    = 1'b1;
                        w_hold_next = '0;
                        if (w_last) begin
                            w_latch     = 1'b1;
                            w_done_next = 1'b1;
                            w_idx_next  = '0;
                            if (r_mode == MODE_CONT) begin
                                w_clear = 1'b1;
                            end else begin
                                w_state_next = IDLE;
                            end
                        end else if (r_mode == MODE_STEP) begin
                            w_state_next = WAIT_STEP;
                        end else begin
                            w_idx_next = r_idx + (N_IN+1)'(1);
                        end
                    end else begin
                        w_hold_next = r_hold + HW'(1);
                    end
                end
                WAIT_STEP: begin
                    if (i_step) begin
                        w_idx_next   = r_idx + (N_IN+1)'(1);
                        w_hold_next  = '0;
                        w_state_next = DRIVE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                    w_hold_next  = '0;
                end
            endcase
        end
    end

    sweep_signature_acc #(
        .N_IN  (N_IN),
        .M_OUT (M_OUT),
        .SIG_W (SIG_W)
    ) u_acc (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_clear),
        .i_update     (w_update),
        .i_latch      (w_latch),
        .i_resp       (i_resp),
        .o_signature  (o_signature),
        .o_ones_count (o_ones_count)
    );

    assign o_stim       = r_idx[N_IN-1:0];
    assign o_sample_idx = r_idx[N_IN-1:0];
    assign o_stim_valid = (r_state != IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_resp_valid = w_sample && !i_abort;
    assign o_done       = r_done;

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
module tb_exhaustive_vector_sweeper;

    localparam int unsigned NV   = 8;   // vectors for the main instance
    localparam int unsigned HOLD = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Instance A: N_IN=3, HOLD=5, 2-bit response (bit 1 exercises zero-extension)
    logic       a_start = 1'b0, a_step = 1'b0, a_abort = 1'b0;
    logic [1:0] a_mode  = 2'd0;
    logic [1:0] a_resp;
    logic [2:0] a_stim, a_sample_idx;
    logic       a_stim_valid, a_resp_valid, a_busy, a_done;
    logic [3:0] a_ones;
    logic [15:0] a_sig;
    logic [1:0] lut_a [NV];

    always_comb a_resp = lut_a[a_stim];

    exhaustive_vector_sweeper #(
        .N_IN(3), .M_OUT(2), .HOLD_CYCLES(HOLD), .SIG_W(16)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_mode(a_mode),
        .i_step(a_step), .i_abort(a_abort), .i_resp(a_resp),
        .o_stim(a_stim), .o_stim_valid(a_stim_valid), .o_resp_valid(a_resp_valid),
        .o_sample_idx(a_sample_idx), .o_busy(a_busy), .o_done(a_done),
        .o_ones_count(a_ones), .o_signature(a_sig)
    );

    // Instance B: N_IN=1, HOLD=1, resp = ~stim
    logic       b_start = 1'b0;
    logic [1:0] b_mode  = 2'd0;
    logic       b_resp;
    logic [0:0] b_stim, b_sample_idx;
    logic       b_stim_valid, b_resp_valid, b_busy, b_done;
    logic [1:0] b_ones;
    logic [15:0] b_sig;

    always_comb b_resp = ~b_stim[0];

    exhaustive_vector_sweeper #(
        .N_IN(1), .M_OUT(1), .HOLD_CYCLES(1), .SIG_W(16)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_mode(b_mode),
        .i_step(1'b0), .i_abort(1'b0), .i_resp(b_resp),
        .o_stim(b_stim), .o_stim_valid(b_stim_valid), .o_resp_valid(b_resp_valid),
        .o_sample_idx(b_sample_idx), .o_busy(b_busy), .o_done(b_done),
        .o_ones_count(b_ones), .o_signature(b_sig)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fold the response table in vector order.
    task automatic model_a(output logic [15:0] sig, output logic [3:0] ones);
        sig  = '0;
        ones = '0;
        for (int v = 0; v < NV; v++) begin
            sig  = {sig[14:0], sig[15]} ^ {14'd0, lut_a[v]};
            ones = ones + {3'd0, lut_a[v][0]};
        end
    endtask

    task automatic set_majority();
        for (int v = 0; v < NV; v++) begin
            logic [2:0] b;
            b = 3'(v);
            lut_a[v] = {1'b0, (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2])};
        end
    endtask

    task automatic set_random_lut();
        for (int v = 0; v < NV; v++) lut_a[v] = 2'($urandom);
    endtask

    // One-shot style pass with cycle-exact checks from the start edge.
    task automatic run_oneshot(input logic [1:0] md, input bit hold_start, input bit noise_step);
        logic [15:0] es;
        logic [3:0]  eo;
        model_a(es, eo);
        a_mode  = md;
        a_start = 1'b1;
        tick();
        if (!hold_start) a_start = 1'b0;
        for (int c = 0; c < NV * HOLD; c++) begin
            chk("os_stim", 32'(a_stim), 32'(c / HOLD));
            chk("os_sidx", 32'(a_sample_idx), 32'(c / HOLD));
            chk("os_rvalid", 32'(a_resp_valid), 32'((c % HOLD) == HOLD - 1));
            chk("os_done_early", 32'(a_done), 32'd0);
            chk("os_busy", 32'(a_busy), 32'd1);
            a_mode = 2'($urandom);
            if (noise_step) a_step = 1'($urandom);
            if (c == NV * HOLD - 1) a_start = 1'b0;
            tick();
        end
        a_step = 1'b0;
        chk("os_done", 32'(a_done), 32'd1);
        chk("os_idle_busy", 32'(a_busy), 32'd0);
        chk("os_idle_stim", 32'(a_stim), 32'd0);
        chk("os_ones", 32'(a_ones), 32'(eo));
        chk("os_sig", 32'(a_sig), 32'(es));
        tick();
        chk("os_done_pulse", 32'(a_done), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] es, new_es;
        logic [3:0]  eo, new_eo;
        int unsigned cnt;

        // Reset state
        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_stim", 32'(a_stim), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_sig", 32'(a_sig), 32'd0);
        chk("rst_ones", 32'(a_ones), 32'd0);
        chk("rst_svalid", 32'(a_stim_valid), 32'd0);
        rst = 1'b0;
        tick();

        // 1: one-shot, majority
        set_majority();
        run_oneshot(2'd0, 1'b0, 1'b0);
        chk("t1_sig_const", 32'(a_sig), 32'h0017);
        chk("t1_ones_const", 32'(a_ones), 32'd4);

        // 2: continuous, then abort on the last sample of the third pass
        model_a(es, eo);
        a_mode = 2'd1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int g = 0; g < 3 * NV * HOLD; g++) begin
            chk("ct_stim", 32'(a_stim), 32'((g % (NV * HOLD)) / HOLD));
            chk("ct_done", 32'(a_done), 32'(g == 40 || g == 80));
            chk("ct_busy", 32'(a_busy), 32'd1);
            if (g == 40 || g == 80) begin
                chk("ct_sig", 32'(a_sig), 32'(es));
                chk("ct_ones", 32'(a_ones), 32'(eo));
            end
            if (g == 80) begin
                set_random_lut();
                model_a(new_es, new_eo);
            end
            if (g == 3 * NV * HOLD - 1) a_abort = 1'b1;
            tick();
        end
        a_abort = 1'b0;
        chk("ab_busy", 32'(a_busy), 32'd0);
        chk("ab_stim", 32'(a_stim), 32'd0);
        chk("ab_svalid", 32'(a_stim_valid), 32'd0);
        chk("ab_done", 32'(a_done), 32'd0);
        chk("ab_sig", 32'(a_sig), 32'(es));
        chk("ab_ones", 32'(a_ones), 32'(eo));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ab_no_done", 32'(a_done), 32'd0);
        end

        // 3: single-step, resp = stim[0]
        for (int v = 0; v < NV; v++) lut_a[v] = {1'b0, 1'(v)};
        model_a(es, eo);
        a_mode = 2'd2; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int v = 0; v < NV; v++) begin
            cnt = 0;
            while (!a_resp_valid && cnt < 50) begin
                tick();
                cnt++;
            end
            chk("st_lat", cnt, HOLD - 1);
            chk("st_stim", 32'(a_stim), 32'(v));
            tick();
            if (v < NV - 1) begin
                for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
                    chk("st_hold_stim", 32'(a_stim), 32'(v));
                    chk("st_hold_svalid", 32'(a_stim_valid), 32'd1);
                    chk("st_hold_rvalid", 32'(a_resp_valid), 32'd0);
                    tick();
                end
                a_step = 1'b1;
                tick();
                a_step = 1'b0;
            end else begin
                chk("st_done", 32'(a_done), 32'd1);
                chk("st_ones", 32'(a_ones), 32'd4);
                chk("st_sig", 32'(a_sig), 32'h0055);
                chk("st_sig_model", 32'(a_sig), 32'(es));
                chk("st_busy", 32'(a_busy), 32'd0);
            end
        end
        tick();

        // 4: async reset mid-sweep at vector 5
        set_majority();
        a_mode = 2'd0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (26) tick();
        chk("ar_pre_stim", 32'(a_stim), 32'd5);
        #3 rst = 1'b1;
        #1;
        chk("ar_stim", 32'(a_stim), 32'd0);
        chk("ar_svalid", 32'(a_stim_valid), 32'd0);
        chk("ar_rvalid", 32'(a_resp_valid), 32'd0);
        chk("ar_busy", 32'(a_busy), 32'd0);
        chk("ar_done", 32'(a_done), 32'd0);
        chk("ar_sig", 32'(a_sig), 32'd0);
        chk("ar_ones", 32'(a_ones), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        run_oneshot(2'd0, 1'b0, 1'b0);
        chk("ar_sig_const", 32'(a_sig), 32'h0017);

        // 5: start held and step noise during a one-shot sweep
        run_oneshot(2'd0, 1'b1, 1'b1);
        chk("hs_sig_const", 32'(a_sig), 32'h0017);
        chk("hs_ones_const", 32'(a_ones), 32'd4);

        // 6: N_IN=1, HOLD=1, resp=~stim
        b_mode = 2'd0; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_stim0", 32'(b_stim), 32'd0);
        chk("b_rv0", 32'(b_resp_valid), 32'd1);
        tick();
        chk("b_stim1", 32'(b_stim), 32'd1);
        chk("b_rv1", 32'(b_resp_valid), 32'd1);
        chk("b_done_early", 32'(b_done), 32'd0);
        tick();
        chk("b_done", 32'(b_done), 32'd1);
        chk("b_ones", 32'(b_ones), 32'd1);
        chk("b_sig", 32'(b_sig), 32'h0002);
        chk("b_busy", 32'(b_busy), 32'd0);
        tick();
        chk("b_done_pulse", 32'(b_done), 32'd0);

        // Random response tables; mode 3 behaves as one-shot
        for (int r = 0; r < 6; r++) begin
            set_random_lut();
            run_oneshot(($urandom % 2) ? 2'd3 : 2'd0, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
